// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;
  localparam int REG_W = 3;
  localparam logic [REG_W-1:0] REG_ZERO = 3'b000;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hz_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)                    q_d = '0;
    else if (inc && q_q != '1)  q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / memory-wait / branch-flush controller for the 5-stage pipeline.
// All pipeline controls are combinational from inputs; only counters, timeout and state are registered.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] PR1_rs,
  input  logic [REG_W-1:0] PR1_rt,
  input  logic             PR1_uses_rt,
  input  logic             PR2_MEM_read,
  input  logic [REG_W-1:0] PR2_rd,
  input  logic             PR3_MEM_read,
  input  logic             PR3_MEM_write,
  input  logic             mem_ready,
  input  logic             branch_taken,
  input  logic             cnt_clr,
  output logic             PC_write_en,
  output logic             PR1_write_en,
  output logic             PR1_flush,
  output logic             PR2_write_en,
  output logic             PR2_flush,
  output logic             PR3_write_en,
  output logic             PR4_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TO_M1 = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t state_q, state_d;
  logic mem_timeout_q, mem_timeout_d;
  logic mem_busy, load_use;
  logic pc_we, pr1_we, pr1_fl, pr2_we, pr2_fl, pr3_we, pr4_fl;
  logic flush_inc, wait_inc, wait_clr;
  logic [WAIT_W-1:0] wait_cnt;

  always_comb begin
    mem_busy = (PR3_MEM_read | PR3_MEM_write) & ~mem_ready;
    load_use = PR2_MEM_read && (PR2_rd != REG_ZERO) &&
               ((PR2_rd == PR1_rs) || (PR1_uses_rt && (PR2_rd == PR1_rt)));
  end

  // Outputs do not depend on state: LOAD_STALL and the MEM_WAIT release
  // cycle decode hazards exactly like RUN, so a held branch fires on release.
  always_comb begin
    pc_we     = 1'b1;
    pr1_we    = 1'b1;
    pr1_fl    = 1'b0;
    pr2_we    = 1'b1;
    pr2_fl    = 1'b0;
    pr3_we    = 1'b1;
    pr4_fl    = 1'b0;
    state_d   = RUN;
    flush_inc = 1'b0;
    wait_inc  = 1'b0;
    wait_clr  = 1'b0;
    if (mem_busy) begin
      pc_we    = 1'b0;
      pr1_we   = 1'b0;
      pr2_we   = 1'b0;
      pr3_we   = 1'b0;
      pr4_fl   = 1'b1;
      state_d  = MEM_WAIT;
      wait_inc = (state_q == MEM_WAIT);
    end else begin
      wait_clr = (state_q == MEM_WAIT);
      if (branch_taken) begin
        pr1_fl    = 1'b1;
        pr2_fl    = 1'b1;
        flush_inc = 1'b1;
      end else if (load_use) begin
        pc_we   = 1'b0;
        pr1_we  = 1'b0;
        pr2_fl  = 1'b1;
        state_d = LOAD_STALL;
      end
    end
    mem_timeout_d = mem_timeout_q | (wait_inc && (wait_cnt >= TO_M1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(~pc_we), .q(stall_count)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(flush_inc), .q(flush_count)
  );
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk(clk), .rst_n(rst_n), .clr(wait_clr), .inc(wait_inc), .q(wait_cnt)
  );

  // Hold the pipeline inert while reset is asserted.
  assign PC_write_en  = rst_n & pc_we;
  assign PR1_write_en = rst_n & pr1_we;
  assign PR2_write_en = rst_n & pr2_we;
  assign PR3_write_en = rst_n & pr3_we;
  assign PR1_flush    = ~rst_n | pr1_fl;
  assign PR2_flush    = ~rst_n | pr2_fl;
  assign PR4_flush    = ~rst_n | pr4_fl;
  assign mem_timeout  = mem_timeout_q;
endmodule
